// File: rtl/blink_cfg_if.sv
// Configuration handshake bundle for blink_controller: request, mode and
// timing fields travel together and are accepted on cfg_valid & cfg_ready.
interface blink_cfg_if #(
  parameter int SIZE  = 26,
  parameter int CNT_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_mode;
  logic [SIZE-1:0]  cfg_half_period;
  logic [CNT_W-1:0] cfg_count;

  modport master (
    output cfg_valid,
    output cfg_mode,
    output cfg_half_period,
    output cfg_count,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_mode,
    input  cfg_half_period,
    input  cfg_count,
    output cfg_ready
  );
endinterface

// File: rtl/blink_controller.sv
// LED controller with OFF / ON / BLINK / BURST modes; BURST emits N pulses of
// H cycles high and H cycles low, then returns to OFF with a done pulse.
module blink_controller #(
  parameter int SIZE  = 26,
  parameter int CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_n,
  blink_cfg_if.slave       cfg,
  input  logic             abort,
  output logic             led_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulses_left
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_ON    = 2'd1,
    ST_BLINK = 2'd2,
    ST_BURST = 2'd3
  } state_e;

  localparam logic [SIZE-1:0]  ONE_H = {{(SIZE-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ONE_P = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_r, state_s;
  logic             led_r, led_s;
  logic             busy_r;
  logic             done_r, done_s;
  logic [SIZE-1:0]  cnt_r, cnt_s;
  logic [SIZE-1:0]  h_r, h_s;
  logic [CNT_W-1:0] n_r, n_s;
  logic [CNT_W-1:0] pulses_r, pulses_s;
  logic             ready_s;
  logic             accept_s;
  logic             phase_end_s;
  logic [SIZE-1:0]  h_in_s;

  assign ready_s     = (state_r != ST_BURST) & ~abort;
  assign accept_s    = cfg.cfg_valid & ready_s;
  assign phase_end_s = (cnt_r == (h_r - ONE_H));
  // A zero half-period is promoted to one so BLINK still toggles every cycle.
  assign h_in_s      = (cfg.cfg_half_period == {SIZE{1'b0}}) ? ONE_H : cfg.cfg_half_period;

  assign cfg.cfg_ready = ready_s;
  assign led_out       = led_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign pulses_left   = pulses_r;

  // Next-state, phase counter and output decode.
  always_comb begin
    state_s  = state_r;
    led_s    = led_r;
    cnt_s    = cnt_r;
    h_s      = h_r;
    n_s      = n_r;
    pulses_s = pulses_r;
    done_s   = 1'b0;
    if (abort) begin
      state_s  = ST_OFF;
      led_s    = 1'b0;
      cnt_s    = {SIZE{1'b0}};
      pulses_s = {CNT_W{1'b0}};
    end else if (accept_s) begin
      state_s  = state_e'(cfg.cfg_mode);
      h_s      = h_in_s;
      n_s      = cfg.cfg_count;
      cnt_s    = {SIZE{1'b0}};
      pulses_s = {CNT_W{1'b0}};
      case (state_e'(cfg.cfg_mode))
        ST_OFF:   led_s = 1'b0;
        ST_ON:    led_s = 1'b1;
        ST_BLINK: led_s = 1'b1;
        ST_BURST: begin
          if (cfg.cfg_count == {CNT_W{1'b0}}) begin
            state_s = ST_OFF;
            led_s   = 1'b0;
            done_s  = 1'b1;
          end else begin
            led_s    = 1'b1;
            pulses_s = cfg.cfg_count;
          end
        end
        default:  led_s = 1'b0;
      endcase
    end else begin
      case (state_r)
        ST_OFF: begin
          led_s = 1'b0;
          cnt_s = {SIZE{1'b0}};
        end
        ST_ON: begin
          led_s = 1'b1;
          cnt_s = {SIZE{1'b0}};
        end
        ST_BLINK: begin
          if (phase_end_s) begin
            cnt_s = {SIZE{1'b0}};
            led_s = ~led_r;
          end else begin
            cnt_s = cnt_r + ONE_H;
          end
        end
        ST_BURST: begin
          if (phase_end_s) begin
            cnt_s = {SIZE{1'b0}};
            if (led_r) begin
              led_s = 1'b0;
            end else if (pulses_r == ONE_P) begin
              // Last low phase over: leave BURST and flag completion together.
              state_s  = ST_OFF;
              led_s    = 1'b0;
              done_s   = 1'b1;
              pulses_s = {CNT_W{1'b0}};
            end else begin
              led_s    = 1'b1;
              pulses_s = pulses_r - ONE_P;
            end
          end else begin
            cnt_s = cnt_r + ONE_H;
          end
        end
        default: begin
          state_s  = ST_OFF;
          led_s    = 1'b0;
          cnt_s    = {SIZE{1'b0}};
          pulses_s = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_OFF;
      led_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      cnt_r    <= {SIZE{1'b0}};
      h_r      <= {SIZE{1'b0}};
      n_r      <= {CNT_W{1'b0}};
      pulses_r <= {CNT_W{1'b0}};
    end else begin
      state_r  <= state_s;
      led_r    <= led_s;
      busy_r   <= (state_s == ST_BURST);
      done_r   <= done_s;
      cnt_r    <= cnt_s;
      h_r      <= h_s;
      n_r      <= n_s;
      pulses_r <= pulses_s;
    end
  end

endmodule

// File: tb/tb_blink_controller.sv
// Self-checking bench for blink_controller: directed scenarios plus random
// traffic compared against a time-since-accept reference model.
module tb_blink_controller;
  localparam int SIZE  = 26;
  localparam int CNT_W = 8;

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic             abort;
  logic             led_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pulses_left;

  int checks = 0;
  int errors = 0;

  // Reference model: mode, cycles elapsed since accept, H and N.
  int m_mode, m_t, m_h, m_n;
  logic m_done;

  blink_cfg_if #(.SIZE(SIZE), .CNT_W(CNT_W)) cfg_bus ();

  blink_controller #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .cfg         (cfg_bus.slave),
    .abort       (abort),
    .led_out     (led_out),
    .busy        (busy),
    .done        (done),
    .pulses_left (pulses_left)
  );

  always #5 clk_in = ~clk_in;

  function automatic void model_reset();
    m_mode = 0; m_t = 0; m_h = 0; m_n = 0; m_done = 1'b0;
  endfunction

  function automatic logic exp_led();
    case (m_mode)
      1:       return 1'b1;
      2:       return ((m_t / m_h) % 2) == 0;
      3:       return (m_t % (2 * m_h)) < m_h;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int exp_pl();
    return (m_mode == 3) ? (m_n - m_t / (2 * m_h)) : 0;
  endfunction

  function automatic logic exp_ready();
    return (m_mode != 3) && !abort;
  endfunction

  // Advance one clock edge and update the model from the inputs seen at it.
  task automatic tick();
    logic acc, ab;
    int md, hp, cn;
    ab  = abort;
    acc = cfg_bus.cfg_valid && (m_mode != 3) && !abort;
    md  = int'(cfg_bus.cfg_mode);
    hp  = int'(cfg_bus.cfg_half_period);
    cn  = int'(cfg_bus.cfg_count);
    @(posedge clk_in);
    #1;
    m_done = 1'b0;
    if (ab) begin
      m_mode = 0; m_t = 0;
    end else if (acc) begin
      m_mode = md; m_h = (hp == 0) ? 1 : hp; m_n = cn; m_t = 0;
    end else if (m_mode >= 2) begin
      m_t++;
    end
    if (m_mode == 3 && m_t == 2 * m_h * m_n) begin
      m_done = 1'b1; m_mode = 0; m_t = 0;
    end
  endtask

  task automatic drive_cfg(input logic v, input int md, input int hp, input int cn);
    cfg_bus.cfg_valid       = v;
    cfg_bus.cfg_mode        = 2'(md);
    cfg_bus.cfg_half_period = SIZE'(hp);
    cfg_bus.cfg_count       = CNT_W'(cn);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; abort = 1'b0;
    drive_cfg(1'b0, 0, 0, 0);
    model_reset();
    repeat (3) @(posedge clk_in);
    #1 rst_n = 1'b1;
    #1;
    checks++; if (led_out !== 1'b0) begin errors++; $display("FAIL reset_led: got %b want 0", led_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (pulses_left !== '0) begin errors++; $display("FAIL reset_pl: got %0d want 0", pulses_left); end
    checks++; if (cfg_bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cfg_bus.cfg_ready); end
  endtask

  task automatic test_blink();
    logic [6:0] pat;
    pat = 7'b1000111;
    drive_cfg(1'b1, 2, 3, int'($urandom_range(0, 9)));
    tick();
    drive_cfg(1'b0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (led_out !== pat[i]) begin errors++; $display("FAIL blink_h3 cyc%0d: got %b want %b", i + 1, led_out, pat[i]); end
      tick();
    end
  endtask

  task automatic test_burst();
    int busy_cycles;
    busy_cycles = 0;
    drive_cfg(1'b1, 3, 2, 3);
    tick();
    for (int i = 0; i < 12; i++) begin
      drive_cfg(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      #1;
      if (busy === 1'b1) busy_cycles++;
      checks++; if (cfg_bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL burst_ready cyc%0d: got %b want 0", i, cfg_bus.cfg_ready); end
      checks++; if (led_out !== ((i % 4) < 2)) begin errors++; $display("FAIL burst_led cyc%0d: got %b want %b", i, led_out, (i % 4) < 2); end
      checks++; if (int'(pulses_left) != 3 - i / 4) begin errors++; $display("FAIL burst_pl cyc%0d: got %0d want %0d", i, pulses_left, 3 - i / 4); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL burst_early_done cyc%0d: got %b want 0", i, done); end
      tick();
    end
    drive_cfg(1'b0, 0, 0, 0);
    #1;
    checks++; if (busy_cycles != 12) begin errors++; $display("FAIL burst_busy_len: got %0d want 12", busy_cycles); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL burst_done: got %b want 1", done); end
    checks++; if (busy !== 1'b0 || led_out !== 1'b0 || pulses_left !== '0) begin
      errors++; $display("FAIL burst_end: busy %b led %b pl %0d want 0 0 0", busy, led_out, pulses_left); end
    tick();
    checks++; if (done !== 1'b0 || led_out !== 1'b0) begin errors++; $display("FAIL burst_after: done %b led %b want 0 0", done, led_out); end
  endtask

  task automatic test_burst_zero();
    drive_cfg(1'b1, 3, int'($urandom_range(0, 5)), 0);
    tick();
    drive_cfg(1'b0, 0, 0, 0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", done); end
    checks++; if (led_out !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_led_busy: led %b busy %b want 0 0", led_out, busy); end
    tick();
    checks++; if (done !== 1'b0 || led_out !== 1'b0) begin errors++; $display("FAIL zero_after: done %b led %b want 0 0", done, led_out); end
  endtask

  task automatic test_abort();
    drive_cfg(1'b1, 3, 2, 5);
    tick();
    drive_cfg(1'b0, 0, 0, 0);
    repeat (5) tick();
    checks++; if (pulses_left !== 8'd4 || led_out !== 1'b1) begin
      errors++; $display("FAIL abort_pre: pl %0d led %b want 4 1", pulses_left, led_out); end
    abort = 1'b1;
    #1;
    checks++; if (cfg_bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL abort_ready_low: got %b want 0", cfg_bus.cfg_ready); end
    tick();
    abort = 1'b0;
    #1;
    checks++; if (led_out !== 1'b0 || pulses_left !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_off: led %b pl %0d busy %b done %b want 0 0 0 0", led_out, pulses_left, busy, done); end
    checks++; if (cfg_bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", cfg_bus.cfg_ready); end
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_no_done cyc%0d: got %b want 0", i, done); end
    end
  endtask

  task automatic test_abort_vs_accept();
    drive_cfg(1'b1, 1, 4, 0);
    abort = 1'b1;
    #1;
    checks++; if (cfg_bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL prio_ready: got %b want 0", cfg_bus.cfg_ready); end
    tick();
    abort = 1'b0;
    drive_cfg(1'b0, 0, 0, 0);
    tick();
    checks++; if (led_out !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL prio_off: led %b busy %b want 0 0", led_out, busy); end
    drive_cfg(1'b1, 2, 0, 0);
    tick();
    drive_cfg(1'b0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      checks++; if (led_out !== ((i % 2) == 0)) begin errors++; $display("FAIL blink_h0 cyc%0d: got %b want %b", i, led_out, (i % 2) == 0); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    drive_cfg(1'b1, 2, 5, 0);
    tick();
    drive_cfg(1'b0, 0, 0, 0);
    repeat (2) tick();
    checks++; if (led_out !== 1'b1) begin errors++; $display("FAIL areset_pre: got %b want 1", led_out); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (led_out !== 1'b0 || busy !== 1'b0 || pulses_left !== '0 || done !== 1'b0) begin
      errors++; $display("FAIL areset_blink: led %b busy %b pl %0d done %b want 0", led_out, busy, pulses_left, done); end
    @(posedge clk_in);
    #1 rst_n = 1'b1;
    model_reset();
    // Reset in the middle of a burst must not produce a done pulse.
    drive_cfg(1'b1, 3, 1, 3);
    tick();
    drive_cfg(1'b0, 0, 0, 0);
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || led_out !== 1'b0 || pulses_left !== '0) begin
      errors++; $display("FAIL areset_burst: busy %b led %b pl %0d want 0 0 0", busy, led_out, pulses_left); end
    @(posedge clk_in);
    #1 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL areset_no_done cyc%0d: got %b want 0", i, done); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      drive_cfg(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
      abort = ($urandom_range(0, 24) == 0);
      #1;
      checks++; if (cfg_bus.cfg_ready !== exp_ready()) begin errors++; $display("FAIL rnd_ready cyc%0d: got %b want %b", i, cfg_bus.cfg_ready, exp_ready()); end
      tick();
      checks++; if (led_out !== exp_led()) begin errors++; $display("FAIL rnd_led cyc%0d: got %b want %b", i, led_out, exp_led()); end
      checks++; if (busy !== (m_mode == 3)) begin errors++; $display("FAIL rnd_busy cyc%0d: got %b want %b", i, busy, m_mode == 3); end
      checks++; if (done !== m_done) begin errors++; $display("FAIL rnd_done cyc%0d: got %b want %b", i, done, m_done); end
      checks++; if (int'(pulses_left) != exp_pl()) begin errors++; $display("FAIL rnd_pl cyc%0d: got %0d want %0d", i, pulses_left, exp_pl()); end
    end
    abort = 1'b0;
    drive_cfg(1'b0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_blink();
    test_burst();
    test_burst_zero();
    test_abort();
    test_abort_vs_accept();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/blink_controller.md
BLINK_CONTROLLER -- requirements
Module: blink_controller

Interface
REQ-001 SHALL have parameter SIZE, default 26, giving the width of the half-period counter and of cfg_half_period.
REQ-002 SHALL have parameter CNT_W, default 8, giving the width of cfg_count and pulses_left.
REQ-003 SHALL have port clk_in  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cfg_valid  input  1  configuration request.
REQ-006 SHALL have port cfg_ready  output  1  configuration can be accepted this cycle.
REQ-007 SHALL have port cfg_mode  input  2  requested mode: 0 OFF, 1 ON, 2 BLINK, 3 BURST.
REQ-008 SHALL have port cfg_half_period  input  SIZE  half-period length in clk_in cycles.
REQ-009 SHALL have port cfg_count  input  CNT_W  number of pulses for BURST.
REQ-010 SHALL have port abort  input  1  forces OFF from any state.
REQ-011 SHALL have port led_out  output  1  registered LED drive.
REQ-012 SHALL have port busy  output  1  high while in BURST.
REQ-013 SHALL have port done  output  1  one-cycle pulse at normal BURST completion.
REQ-014 SHALL have port pulses_left  output  CNT_W  remaining BURST pulses, including the current one.

Function
REQ-015 SHALL implement the states OFF, ON, BLINK and BURST, with the state encoded equal to the cfg_mode values.
REQ-016 SHALL drive cfg_ready = (state != BURST) & ~abort, combinationally.
REQ-017 SHALL define accept = cfg_valid & cfg_ready, and on accept SHALL latch mode, H = max(cfg_half_period, 1) and N = cfg_count.
REQ-018 SHALL, on accept, clear the phase counter and drive led_out in the next cycle to: OFF 0, ON 1, BLINK 1, BURST 1 (or 0 if N = 0).
REQ-019 SHALL make the phase counter count 0..H-1 in BLINK and BURST only; at H-1 it wraps to 0 and marks a phase boundary.
REQ-020 SHALL, in BLINK, toggle led_out at every phase boundary: exactly H cycles high, then H cycles low, repeating.
REQ-021 SHALL hold the counter at 0 in OFF and ON, with led_out constant.
REQ-022 SHALL, in BURST, load pulses_left = N on accept and run each pulse as H cycles high followed by H cycles low.
REQ-023 SHALL, in BURST, decrement pulses_left at the end of each low phase.
REQ-024 SHALL, when the low phase ends with pulses_left = 1, go to OFF with led_out 0, assert done for one cycle and set pulses_left to 0, all at the same edge.
REQ-025 SHALL, on a BURST accept with N = 0, send no pulse, assert done in the cycle after accept and go to OFF.
REQ-026 SHALL keep pulses_left at 0 outside BURST.
REQ-027 SHALL make busy = (state == BURST), registered with the state.
REQ-028 SHALL, when abort is high, go to OFF at the next edge: led_out 0, counter 0, pulses_left 0, no done pulse.
REQ-029 SHALL give abort priority over accept, because cfg_ready is low whenever abort is high.
REQ-030 SHALL let an accept in OFF, ON or BLINK take effect immediately, discarding the phase in progress.
REQ-031 SHALL ignore all cfg_* inputs while in BURST.
REQ-032 SHALL treat H = 1 in BLINK as a toggle every cycle.
REQ-033 SHALL let the SIZE-bit counter reach 2^SIZE-1 without overflow.

Reset
REQ-034 SHALL, while rst_n is low, immediately force: state OFF, led_out 0, counter 0, pulses_left 0, busy 0, done 0.
REQ-035 SHALL, while rst_n is low, also clear the latched H and N.
REQ-036 SHALL, after rst_n deasserts, present cfg_ready = 1 (when abort is low) from the first edge.
REQ-037 SHALL, on reset mid-BURST, produce no done pulse.

Verification
REQ-038 SHALL check: reset release, then mode 2 with half_period 3 accepted at cycle k -> led_out 1 for cycles k+1..k+3, 0 for k+4..k+6, 1 at k+7.
REQ-039 SHALL check: mode 3 with half_period 2, count 3 -> 3 pulses of 2 high / 2 low, busy high for 12 cycles, cfg_ready low throughout, done in the cycle after the last low phase, then led_out 0.
REQ-040 SHALL check: mode 3 with count 0 -> led_out stays 0 and done pulses exactly one cycle after accept.
REQ-041 SHALL check: abort during the 2nd pulse of a count-5 BURST -> next cycle OFF, led_out 0, pulses_left 0, no done, cfg_ready 1.
REQ-042 SHALL check: cfg_valid with mode 1 and abort high in the same cycle -> cfg_ready 0 and the state ends OFF; half_period 0 in BLINK toggles every cycle.
REQ-043 SHALL check: rst_n low asynchronously mid-BLINK -> led_out 0 with no clock edge; cfg held valid during BURST is never accepted.
